// File: rtl/adau1761_spi_responder.sv
// SPI-mode control-port responder: lock sequence, chip/address/data framing, 256-byte register page.
// Define ADAU1761_RESPONDER_AUTOINC_EN to advance the working address after every data byte (bursts).
module adau1761_spi_responder #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] REG_PAGE    = 8'h40
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        sclk,
   input  logic        cs,
   input  logic        sdi,
   output logic        sdo,
   output logic        spi_mode,
   output logic        wr_strobe,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   input  logic [7:0]  host_addr,
   output logic [7:0]  host_data
);
   typedef enum logic [2:0] {ST_IDLE, ST_CHIP, ST_ADDR, ST_DATA, ST_IGNORE} state_t;
   state_t state_reg, state_next;

   logic [SYNC_STAGES-1:0] sclk_sync_reg, cs_sync_reg, sdi_sync_reg;
   logic [SYNC_STAGES:0]   valid_pipe_reg;
   logic                   sclk_prev_reg, cs_prev_reg;
   logic                   sclk_s, cs_s, sdi_s, edges_ok;
   logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

   logic [1:0]  lock_cnt_reg;
   logic        spi_mode_reg;
   logic [3:0]  bit_cnt_reg;
   logic [14:0] shift_reg;
   logic        rnw_reg, load_tx_reg, sdo_reg, sdo_next;
   logic [15:0] addr_reg;
   logic [7:0]  tx_reg, rx_byte, rd_byte;
   logic        wr_strobe_reg;
   logic [15:0] wr_addr_reg;
   logic [7:0]  wr_data_reg, host_data_reg;
   logic        in_page, bit_step, last_bit, byte_done, wr_en;
   logic [7:0]  regfile [256];

   // Edges are trusted only once every stage (and the edge-detect flop) holds a real pin sample,
   // so a cs already low when reset releases is not mistaken for a fresh cs fall.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sclk_sync_reg  <= '0;
         cs_sync_reg    <= '1;
         sdi_sync_reg   <= '0;
         valid_pipe_reg <= '0;
         sclk_prev_reg  <= 1'b0;
         cs_prev_reg    <= 1'b1;
      end else begin
         sclk_sync_reg  <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
         cs_sync_reg    <= {cs_sync_reg[SYNC_STAGES-2:0], cs};
         sdi_sync_reg   <= {sdi_sync_reg[SYNC_STAGES-2:0], sdi};
         valid_pipe_reg <= {valid_pipe_reg[SYNC_STAGES-1:0], 1'b1};
         sclk_prev_reg  <= sclk_s;
         cs_prev_reg    <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
   assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync_reg[SYNC_STAGES-1];
   assign edges_ok  = valid_pipe_reg[SYNC_STAGES];
   assign sclk_rise = edges_ok & sclk_s & ~sclk_prev_reg;
   assign sclk_fall = edges_ok & ~sclk_s & sclk_prev_reg;
   assign cs_fall   = edges_ok & ~cs_s & cs_prev_reg;
   assign cs_rise   = edges_ok & cs_s & ~cs_prev_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_cnt_reg <= 2'd0;
         spi_mode_reg <= 1'b0;
      end else if (cs_fall && !spi_mode_reg) begin
         lock_cnt_reg <= lock_cnt_reg + 2'd1;
         if (lock_cnt_reg == 2'd2)
            spi_mode_reg <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      in_page  = addr_reg[15:8] == REG_PAGE;
      bit_step = sclk_rise && !cs_rise && (state_reg inside {ST_CHIP, ST_ADDR, ST_DATA});
      last_bit = 1'b0;
      case (state_reg)
         ST_CHIP: last_bit = bit_cnt_reg == 4'd7;
         ST_ADDR: last_bit = bit_cnt_reg == 4'd15;
         ST_DATA: last_bit = bit_cnt_reg == 4'd7;
         default: last_bit = 1'b0;
      endcase
      rx_byte   = {shift_reg[6:0], sdi_s};
      byte_done = bit_step && last_bit && (state_reg == ST_DATA);
      wr_en     = byte_done && !rnw_reg && in_page;
      rd_byte   = in_page ? regfile[addr_reg[7:0]] : 8'h00;

      sdo_next = 1'b0;
      if (state_reg == ST_DATA && rnw_reg && !cs_rise)
         sdo_next = sclk_fall ? tx_reg[7] : sdo_reg;

      state_next = state_reg;
      if (cs_rise)
         state_next = ST_IDLE;
      else begin
         case (state_reg)
            ST_IDLE: if (cs_fall) state_next = spi_mode_reg ? ST_CHIP : ST_IGNORE;
            ST_CHIP: if (bit_step && last_bit) state_next = ST_ADDR;
            ST_ADDR: if (bit_step && last_bit) state_next = ST_DATA;
            ST_DATA: begin
`ifndef ADAU1761_RESPONDER_AUTOINC_EN
               if (byte_done) state_next = ST_IGNORE;
`endif
            end
            ST_IGNORE: state_next = ST_IGNORE;
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bit_cnt_reg   <= 4'd0;
         shift_reg     <= '0;
         rnw_reg       <= 1'b0;
         addr_reg      <= 16'h0000;
         load_tx_reg   <= 1'b0;
         tx_reg        <= 8'h00;
         sdo_reg       <= 1'b0;
         wr_strobe_reg <= 1'b0;
         wr_addr_reg   <= 16'h0000;
         wr_data_reg   <= 8'h00;
         host_data_reg <= 8'h00;
      end else begin
         load_tx_reg   <= 1'b0;
         wr_strobe_reg <= wr_en;
         sdo_reg       <= sdo_next;
         host_data_reg <= regfile[host_addr];
         if (wr_en) begin
            wr_addr_reg <= addr_reg;
            wr_data_reg <= rx_byte;
         end
         if (state_reg == ST_IDLE) begin
            bit_cnt_reg <= 4'd0;
            shift_reg   <= '0;
         end else if (bit_step) begin
            shift_reg   <= {shift_reg[13:0], sdi_s};
            bit_cnt_reg <= last_bit ? 4'd0 : bit_cnt_reg + 4'd1;
            if (state_reg == ST_CHIP && last_bit)
               rnw_reg <= sdi_s;
            if (state_reg == ST_ADDR && last_bit) begin
               addr_reg    <= {shift_reg, sdi_s};
               load_tx_reg <= 1'b1;
            end
`ifdef ADAU1761_RESPONDER_AUTOINC_EN
            if (byte_done) begin
               addr_reg    <= addr_reg + 16'd1;
               load_tx_reg <= 1'b1;
            end
`endif
         end
         // Read byte is fetched one clk after the address settles; the next sclk fall is always later.
         if (load_tx_reg)
            tx_reg <= rd_byte;
         else if (state_reg == ST_DATA && sclk_fall)
            tx_reg <= {tx_reg[6:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 256; i++)
            regfile[i] <= 8'h00;
      end else if (wr_en) begin
         regfile[addr_reg[7:0]] <= rx_byte;
      end
   end

   assign sdo       = sdo_reg;
   assign spi_mode  = spi_mode_reg;
   assign wr_strobe = wr_strobe_reg;
   assign wr_addr   = wr_addr_reg;
   assign wr_data   = wr_data_reg;
   assign host_data = host_data_reg;
endmodule

// File: doc/adau1761_spi_responder.md
ADAU1761_SPI_RESPONDER -- requirements
Module: adau1761_spi_responder

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for sclk, cs and sdi (min 2).
REQ-002 The block SHALL have parameter REG_PAGE, default 8'h40: upper address byte that selects the register file.
REQ-003 Port clk, input, 1 bit: the single system clock; SHALL run at least 4x sclk frequency.
REQ-004 Port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port sclk, input, 1 bit: SPI clock from the controller, asynchronous to clk.
REQ-006 Port cs, input, 1 bit: SPI chip select, active-low.
REQ-007 Port sdi, input, 1 bit: controller-to-responder data, MSB first.
REQ-008 Port sdo, output, 1 bit: responder-to-controller read data, MSB first.
REQ-009 Port spi_mode, output, 1 bit: high once SPI-mode lock is achieved.
REQ-010 Port wr_strobe, output, 1 bit: one-clk pulse per committed register write.
REQ-011 Port wr_addr, output, 16 bits: address of the committed write.
REQ-012 Port wr_data, output, 8 bits: data of the committed write.
REQ-013 Port host_addr, input, 8 bits: local read address into the register file.
REQ-014 Port host_data, output, 8 bits: register file contents at host_addr, registered, 1 clk latency.

Function
REQ-015 sclk, cs and sdi SHALL pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized signals only.
REQ-016 sdi SHALL be sampled on each synchronized sclk rising edge while cs is low; sdo SHALL update on each synchronized sclk falling edge.
REQ-017 Lock: while spi_mode is low, each cs falling edge SHALL increment a 2-bit counter; on the third, spi_mode SHALL go high and stay high until reset.
REQ-018 Transactions beginning while spi_mode is low (including the third) SHALL be ignored: no writes, sdo held 0.
REQ-019 FSM states: IDLE, CHIP, ADDR, DATA, IGNORE. IDLE->CHIP on cs fall with spi_mode high; IDLE->IGNORE on cs fall with spi_mode low.
REQ-020 CHIP: receive 8 bits; bit0 = R/nW, bits[7:1] ignored; then ADDR.
REQ-021 ADDR: receive 16 address bits MSB first into the working address; then DATA.
REQ-022 DATA write: after each 8th bit, if address[15:8]==REG_PAGE, regfile[address[7:0]] SHALL be written and wr_strobe pulsed with wr_addr/wr_data, no later than SYNC_STAGES+2 clk cycles after that sclk rising edge.
REQ-023 DATA write out of page: byte SHALL be dropped, no wr_strobe.
REQ-024 DATA read: the first data bit SHALL be on sdo after the falling edge following the 24th rising edge; byte = regfile[address[7:0]] in page, 8'h00 out of page.
REQ-025 A cs rise in any state SHALL return the FSM to IDLE within one clk, discard any partial byte, and drive sdo 0.
REQ-026 The working address SHALL be a 16-bit counter wrapping 16'hFFFF->16'h0000; 16'h40FF+1 = 16'h4100 is out of page.
REQ-027 A host_addr read coinciding with an SPI write to the same entry SHALL return the old value that cycle, the new value next cycle.

Reset
REQ-028 On resetn low: sdo=0, spi_mode=0, wr_strobe=0, wr_addr=0, wr_data=0, host_data=0, lock counter=0, FSM=IDLE, synchronizers cleared to idle levels (cs=1, sclk=0).
REQ-029 The register file SHALL reset to all 8'h00.
REQ-030 Reset asserted mid-transaction SHALL abort it; after release the FSM SHALL wait in IDLE for a fresh cs fall, and the lock sequence SHALL be required again.

Configuration
REQ-031 Macro ADAU1761_RESPONDER_AUTOINC_EN defined: after each data byte the working address SHALL increment, permitting bursts.
REQ-032 Macro undefined: only the first data byte SHALL be acted on; further bytes SHALL be ignored (no writes, sdo 0) until cs rises.

Verification
REQ-033 Three empty cs pulses then write 00/4000/01 -> spi_mode=1 after third pulse; wr_strobe once with 16'h4000/8'h01; host_data(8'h00)=8'h01.
REQ-034 Write 00/400B/05 before lock -> no wr_strobe; regfile[8'h0B] stays 8'h00.
REQ-035 After lock, write 00/40F9/7F, then read 01/40F9 -> sdo shifts 8'h7F in bits 25-32.
REQ-036 Write 00/3000/AA and read 01/3000 -> no wr_strobe; read returns 8'h00.
REQ-037 AUTOINC_EN: burst 00/40FE/11/22/33 -> writes at 40FE, 40FF; 4100 dropped. Without macro -> only 40FE written.
REQ-038 cs rise after 5 data bits, and resetn pulse mid-address -> no write; FSM IDLE; after reset spi_mode=0.
